// File: rtl/ksa_pkg.sv
// Shared definitions for the multi-precision Kogge-Stone add/subtract sequencer:
// default geometry, the sequencer state encoding and the counter-width helper.
package ksa_pkg;

   localparam int DEF_SLICE_W    = 8;
   localparam int DEF_NUM_SLICES = 4;

   // One counter walks operand beats (0..2N-1), then slices, then result beats.
   function automatic int cnt_width(input int num_slices);
      return $clog2(2 * num_slices);
   endfunction

   localparam int CNT_W = cnt_width(DEF_NUM_SLICES);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      ADD  = 2'd1,
      OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/ksa_slice.sv
// Combinational SLICE_W-bit Kogge-Stone adder slice: parallel-prefix carry tree
// with the carry-in folded into bit 0's generate term.
module ksa_slice #(
   parameter int SLICE_W = 8
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [SLICE_W-1:0] half_sum;
   logic [SLICE_W-1:0] grp_g;
   logic [SLICE_W-1:0] grp_p;
   logic [SLICE_W-1:0] nxt_g;
   logic [SLICE_W-1:0] nxt_p;

   // After the prefix levels, grp_g[i] is the carry out of bit i including cin.
   always_comb begin
      half_sum = a ^ b;
      grp_g    = a & b;
      grp_p    = a ^ b;
      nxt_g    = '0;
      nxt_p    = '0;
      grp_g[0] = grp_g[0] | (grp_p[0] & cin);
      for (int d = 1; d < SLICE_W; d = d * 2) begin
         nxt_g = grp_g;
         nxt_p = grp_p;
         for (int i = d; i < SLICE_W; i++) begin
            nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
            nxt_p[i] = grp_p[i] & grp_p[i-d];
         end
         grp_g = nxt_g;
         grp_p = nxt_p;
      end
   end

   assign sum  = half_sum ^ {grp_g[SLICE_W-2:0], cin};
   assign cout = grp_g[SLICE_W-1];

endmodule

// File: rtl/ksa_add_sequencer.sv
// Streams two NUM_SLICES*SLICE_W-bit operands in byte beats, adds or subtracts them
// one slice per cycle through a single Kogge-Stone slice, and streams the result out.
module ksa_add_sequencer
   import ksa_pkg::*;
#(
   parameter int SLICE_W    = DEF_SLICE_W,
   parameter int NUM_SLICES = DEF_NUM_SLICES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SLICE_W-1:0] in_data,
   input  logic               in_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SLICE_W-1:0] out_data,
   output logic               out_last,
   output logic               carry_out,
   output logic               overflow,
   output logic               busy
);

   localparam int CW = cnt_width(NUM_SLICES);
   localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CW-1:0] LAST_LOAD  = CW'(2 * NUM_SLICES - 1);
   localparam logic [CW-1:0] LAST_SLICE = CW'(NUM_SLICES - 1);

   state_t state;
   state_t next_state;

   logic [CW-1:0]      cnt;
   logic [IW-1:0]      idx;
   logic [IW-1:0]      load_idx;
   logic               load_sel_b;
   logic [SLICE_W-1:0] a_buf [NUM_SLICES];
   logic [SLICE_W-1:0] b_buf [NUM_SLICES];
   logic [SLICE_W-1:0] s_buf [NUM_SLICES];
   logic               sub_q;
   logic               carry_q;
   logic               ovf_q;

   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic               slice_cin;
   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         LOAD: if (in_valid && cnt == LAST_LOAD) next_state = ADD;
         ADD:  if (cnt == LAST_SLICE) next_state = OUT;
         OUT:  if (out_ready && cnt == LAST_SLICE) next_state = LOAD;
         default: next_state = LOAD;
      endcase
   end

   // Beats 0..N-1 fill A, beats N..2N-1 fill B at the same slice positions.
   always_comb begin
      idx        = IW'(cnt);
      load_sel_b = (cnt >= CW'(NUM_SLICES));
      load_idx   = load_sel_b ? IW'(cnt - CW'(NUM_SLICES)) : IW'(cnt);
   end

   // The slice only sees live operands during ADD; otherwise it idles at zero.
   always_comb begin
      slice_a   = '0;
      slice_b   = '0;
      slice_cin = 1'b0;
      if (state == ADD) begin
         slice_a   = a_buf[idx];
         slice_b   = b_buf[idx] ^ {SLICE_W{sub_q}};
         slice_cin = carry_q;
      end
   end

   ksa_slice #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (slice_cin),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < NUM_SLICES; i++) begin
            a_buf[i] <= '0;
            b_buf[i] <= '0;
            s_buf[i] <= '0;
         end
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  if (cnt == '0) sub_q <= in_sub;
                  if (load_sel_b) b_buf[load_idx] <= in_data;
                  else            a_buf[load_idx] <= in_data;
                  if (cnt == LAST_LOAD) begin
                     cnt     <= '0;
                     carry_q <= sub_q;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ADD: begin
               s_buf[idx] <= slice_sum;
               carry_q    <= slice_cout;
               if (cnt == LAST_SLICE) begin
                  ovf_q <= (slice_a[SLICE_W-1] == slice_b[SLICE_W-1]) &&
                           (slice_sum[SLICE_W-1] != slice_a[SLICE_W-1]);
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  if (cnt == LAST_SLICE) cnt <= '0;
                  else                   cnt <= cnt + CW'(1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   // Outputs decode registered state only, so nothing here depends on in_valid/out_ready.
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      case (state)
         LOAD: in_ready = 1'b1;
         ADD:  busy = 1'b1;
         OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = s_buf[idx];
            out_last  = (cnt == LAST_SLICE);
            carry_out = carry_q;
            overflow  = ovf_q;
         end
         default: in_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ksa_add_sequencer.sv
// Directed bench for ksa_add_sequencer: a signed/unsigned arithmetic model predicts
// every result beat, a negedge compare process checks it, literals pin the model.
module tb_ksa_add_sequencer;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_sub = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         out_ready = 1'b1;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         carry_out;
   logic         overflow;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      logic         carry;
      logic         ovf;
   } beat_t;

   beat_t       exp_q[$];
   int          done_cnt = 0;
   int          beat_i = 0;
   logic [31:0] got_word = '0;
   logic        got_carry = 1'b0;
   logic        got_ovf = 1'b0;

   ksa_add_sequencer #(
      .SLICE_W    (W),
      .NUM_SLICES (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .carry_out (carry_out),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Result follows from integer arithmetic: wrap to 32 bits, carry = no unsigned
   // overflow (add) or no borrow (sub), overflow = signed result out of range.
   task automatic modelOp(input logic [31:0] a, input logic [31:0] b, input logic sub);
      longint sa, sb, sr, ua, ub, ur;
      logic [31:0] res;
      logic carry, ovf;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      sr = sub ? sa - sb : sa + sb;
      ur = sub ? ua - ub : ua + ub;
      res   = ur[31:0];
      carry = sub ? (a >= b) : (ur > 64'sh0_FFFF_FFFF);
      ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      for (int k = 0; k < N; k++)
         exp_q.push_back('{res[8*k +: 8], (k == N - 1), carry, ovf});
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got data %h with no beat pending", out_data);
         end else begin
            checkOutput("out_data", out_data, exp_q[0].data);
            checkOutput("out_last", out_last, exp_q[0].last);
            checkOutput("carry_out", carry_out, exp_q[0].carry);
            checkOutput("overflow", overflow, exp_q[0].ovf);
            if (out_ready) begin
               if (beat_i < N) got_word[8*beat_i +: 8] = out_data;
               beat_i++;
               if (out_last) begin
                  got_carry = carry_out;
                  got_ovf   = overflow;
                  beat_i    = 0;
                  done_cnt++;
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // in_sub is inverted after beat 0 so a DUT that resamples it gets caught.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, output int accept_cyc);
      int guard;
      for (int i = 0; i < 2 * N; i++) begin
         in_valid = 1'b1;
         if (i < N) in_data = a[8*i +: 8];
         else       in_data = b[8*(i-N) +: 8];
         in_sub = (i == 0) ? sub : ~sub;
         guard = 0;
         @(negedge clk);
         while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1 at beat %0d", i);
         end
         @(posedge clk);
         #1;
      end
      accept_cyc = cyc - 1;
      in_valid = 1'b0;
      in_sub   = 1'b0;
      in_data  = '0;
   endtask

   task automatic waitOutValid(input int accept_cyc);
      while (!out_valid && (cyc - accept_cyc) < 20) @(negedge clk);
      checkOutput("latency", cyc - accept_cyc, 5);
   endtask

   task automatic waitDone(input int start_done);
      int guard = 0;
      while (done_cnt == start_done && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got %0d results expected %0d", done_cnt, start_done + 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int acc;
      int start;
      start = done_cnt;
      modelOp(a, b, sub);
      applyStimulus(a, b, sub, acc);
      @(negedge clk);
      checkOutput("busy_in_add", busy, 1);
      checkOutput("in_ready_in_add", in_ready, 0);
      waitOutValid(acc);
      waitDone(start);
   endtask

   task automatic pinResult(input string name, input logic [31:0] word,
                            input logic carry, input logic ovf);
      checkOutput({name, "_word"}, got_word, word);
      checkOutput({name, "_carry"}, got_carry, carry);
      checkOutput({name, "_ovf"}, got_ovf, ovf);
   endtask

   initial begin
      int acc;
      int start;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_carry", carry_out, 0);
      checkOutput("rst_overflow", overflow, 0);
      @(posedge clk);
      #1;

      runOp(32'h0000_00FF, 32'h0000_0001, 1'b0);
      pinResult("t1", 32'h0000_0100, 1'b0, 1'b0);
      runOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      pinResult("t2", 32'h0000_0000, 1'b1, 1'b0);
      runOp(32'h0000_0005, 32'h0000_0007, 1'b1);
      pinResult("t3", 32'hFFFF_FFFE, 1'b0, 1'b0);
      runOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      pinResult("t4a", 32'h8000_0000, 1'b0, 1'b1);
      runOp(32'h8000_0000, 32'h0000_0001, 1'b1);
      pinResult("t4b", 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Backpressure: stall after beat 0 while wiggling in_valid.
      start = done_cnt;
      modelOp(32'h0000_FF80, 32'h0000_0181, 1'b0);
      applyStimulus(32'h0000_FF80, 32'h0000_0181, 1'b0, acc);
      @(negedge clk);
      waitOutValid(acc);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         in_valid = ~in_valid;
         in_data  = W'($urandom);
         @(negedge clk);
         checkOutput("stall_data", out_data, 8'h01);
         checkOutput("stall_valid", out_valid, 1);
         checkOutput("stall_in_ready", in_ready, 0);
         checkOutput("stall_busy", busy, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      waitDone(start);
      pinResult("t5", 32'h0001_0101, 1'b0, 1'b0);

      // Reset during ADD slice 2 discards the operation entirely.
      applyStimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, acc);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      beat_i = 0;
      @(negedge clk);
      checkOutput("abort_in_ready", in_ready, 1);
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_busy", busy, 0);
      @(posedge clk);
      #1;
      runOp(32'h1234_5678, 32'h1111_1111, 1'b0);
      pinResult("t6", 32'h2345_6789, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ksa_add_sequencer.md
# ksa_add_sequencer

Multi-precision add/subtract sequencer for the Kogge-Stone adder array. It streams two wide operands in one byte per beat and pushes them through a single SLICE_W-bit Kogge-Stone slice, least-significant slice first, carrying between slices. It then streams out the result bytes with carry and signed-overflow flags. It sits between the tile's byte-wide I/O glue and the adder, so one small adder can serve NUM_SLICES×SLICE_W-bit arithmetic.

## Interface
- SLICE_W, 8: adder slice width and byte-beat width.
- NUM_SLICES, 4: slices per operand; operand width is NUM_SLICES×SLICE_W (32 by default).

- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  sequencer accepts a beat. High only in LOAD.
- in_data  in  SLICE_W  operand beat. Order: A0..A(N-1), then B0..B(N-1), LSB slice first.
- in_sub  in  1  sampled only on beat 0. 1 = A−B, 0 = A+B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- out_data  out  SLICE_W  result slice, LSB slice first.
- out_last  out  1  marks the final result beat.
- carry_out  out  1  final carry out of the MSB slice. For subtract, 1 = no borrow. Valid while out_valid.
- overflow  out  1  signed overflow of the full-width result. Valid while out_valid.
- busy  out  1  high in ADD or OUT.

## Operation
- States:
  - LOAD: accept 2N beats; byte counter 0..2N−1.
  - ADD: N cycles; slice index k = 0..N−1.
  - OUT: N beats.
- LOAD → ADD after beat 2N−1 is accepted. ADD → OUT after slice N−1. OUT → LOAD on the handshake of the beat that has out_last set.
- In ADD cycle k, slice inputs are:
  - a = A[k]
  - b = B[k] XOR {SLICE_W{sub}}
  - cin = carry register
- The carry register is initialised to sub on entry to ADD. At each slice, the sum is registered into the result buffer and cout into the carry register.
- overflow = (A_msb == B'_msb) && (S_msb != A_msb), where B' is B after the subtract inversion. It is computed during ADD slice N−1.
- All arithmetic is modulo 2^(N×SLICE_W). No sign extension.
- in_valid is ignored outside LOAD. Changes to in_sub after beat 0 are ignored.
- out_ready low stalls indefinitely. out_data, out_last, carry_out and overflow hold stable while stalled.
- Outside ADD, slice inputs are driven to 0.

## Timing
- Reset values:
  - state = LOAD; all counters 0; result buffer 0.
  - out_valid = 0, out_data = 0, out_last = 0, carry_out = 0, overflow = 0, busy = 0.
  - in_ready = 1 from the first cycle with rst low.
- in_ready, busy and out_valid decode the state register directly. There is no combinational path from in_valid or out_ready to any output.
- Throughput in LOAD: one beat per cycle while in_valid is high.
- Latency:
  - Beat 2N−1 is accepted at edge t.
  - ADD runs over cycles t+1..t+N.
  - out_valid rises at cycle t+N+1 (t+5 with the defaults).
- Result beats transfer at one per cycle when out_ready is held high. in_ready rises in the cycle after the out_last handshake.
- Minimum op period: 2N + N + N = 16 cycles with the defaults.
- Reset in any state, including mid-ADD or mid-OUT: the next cycle is LOAD with reset values. The partial operation is discarded and no further result beats are emitted.

## Structure
- Shared package ksa_pkg holds:
  - SLICE_W and NUM_SLICES defaults
  - the state enum {LOAD, ADD, OUT}
  - the counter-width helper constant $clog2(2×NUM_SLICES)
- One sub-module, ksa_slice: the existing combinational SLICE_W-bit Kogge-Stone adder (a, b, cin → sum, cout), instantiated once.
- Operand buffers A and B and the result buffer S are each N×SLICE_W flops, indexed by slice counter.

## Test plan
1. Add 0x000000FF + 0x00000001, out_ready high → beats 00,01,00,00; out_last on beat 3; carry_out 0; overflow 0; out_valid exactly 5 cycles after the last input accept.
2. Add 0xFFFFFFFF + 0x00000001 → beats 00,00,00,00; carry_out 1; overflow 0.
3. Subtract (in_sub = 1) 0x00000005 − 0x00000007 → beats FE,FF,FF,FF; carry_out 0 (borrow); overflow 0.
4. Add 0x7FFFFFFF + 0x00000001 → beats 00,00,00,80; carry_out 0; overflow 1. Subtract 0x80000000 − 0x00000001 → overflow 1.
5. Backpressure: drop out_ready for 3 cycles on beat 1 → out_data stays 01 and flags stay stable; in_ready stays 0; toggling in_valid changes nothing; the stream resumes correctly.
6. Assert rst for one cycle during ADD slice 2 → next cycle in_ready = 1, out_valid = 0, busy = 0; a following op 0x12345678 + 0x11111111 returns 89,67,45,23 with carry_out 0 and overflow 0.
